ram_port_arbiter: RTL and testbench

// Shares the single-port data RAM between two requesters: port 0 = CPU load/store path,

---
 rtl/ram_port_arbiter.sv | 104 ++++++++++
 tb/tb_ram_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin two-port arbiter for a single-port data RAM
module ram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              cpu_stall,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t            state;
  logic              last_winner;
  logic              rd_owner;
  logic [2:0]        rd_cnt;
  logic [ADDR_W-1:0] rd_addr;

  logic              rd_done;
  logic              can_issue;
  logic              grant;
  logic              win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Arbitration and RAM pin drive: a finishing read frees the RAM in the same cycle
  always_comb begin
    rd_done   = (state == RD_WAIT) && (rd_cnt == 3'd1);
    can_issue = !rst && ((state == IDLE) || rd_done);
    win       = (req0 && req1) ? ~last_winner : req1;
    grant     = can_issue && (req0 || req1);
    win_we    = win ? we1    : we0;
    win_addr  = win ? addr1  : addr0;
    win_wdata = win ? wdata1 : wdata0;

    gnt0      = grant && !win;
    gnt1      = grant && win;
    mem_we    = grant && win_we;
    mem_wdata = grant ? win_wdata : '0;
    if (grant)
      mem_addr = win_addr;
    else if (state == RD_WAIT)
      mem_addr = rd_addr;
    else
      mem_addr = '0;

    rvalid0   = rd_done && !rd_owner;
    rvalid1   = rd_done && rd_owner;
    rdata0    = rvalid0 ? mem_rdata : '0;
    rdata1    = rvalid1 ? mem_rdata : '0;

    // Stalled while waiting for a grant, or from read issue until its data returns
    cpu_stall = !rst && ((req0 && !gnt0) || (gnt0 && !we0) ||
                         ((state == RD_WAIT) && !rd_owner && !rvalid0));
  end

  // FSM: track the single outstanding read and the round-robin history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= 1'b1;
      rd_owner    <= 1'b0;
      rd_cnt      <= 3'd0;
      rd_addr     <= '0;
    end else begin
      if (state == RD_WAIT)
        rd_cnt <= rd_cnt - 3'd1;
      if (rd_done)
        state <= IDLE;
      if (grant) begin
        last_winner <= win;
        if (!win_we) begin
          state    <= RD_WAIT;
          rd_cnt   <= LAT;
          rd_owner <= win;
          rd_addr  <= win_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter at RD_LAT 1 and 3
module tb_ram_port_arbiter;

  typedef struct {
    int          cyc;
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel3 = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;

  logic        o1_gnt0, o1_gnt1, o1_rv0, o1_rv1, o1_stall, o1_we;
  logic [31:0] o1_rd0, o1_rd1, o1_addr, o1_wdata, o1_mrd;
  logic        o3_gnt0, o3_gnt1, o3_rv0, o3_rv1, o3_stall, o3_we;
  logic [31:0] o3_rd0, o3_rd1, o3_addr, o3_wdata, o3_mrd;

  logic        m_gnt0, m_gnt1, m_rv0, m_rv1, m_stall, m_we;
  logic [31:0] m_rd0, m_rd1, m_addr, m_wdata;

  logic [31:0] ram1 [0:255];
  logic [31:0] ram3 [0:255];
  logic [31:0] p3 [0:2];

  exp_t qg[$];
  exp_t qr[$];

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) d1 (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(o1_gnt0), .rvalid0(o1_rv0), .rdata0(o1_rd0), .cpu_stall(o1_stall),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(o1_gnt1), .rvalid1(o1_rv1), .rdata1(o1_rd1),
    .mem_we(o1_we), .mem_addr(o1_addr), .mem_wdata(o1_wdata), .mem_rdata(o1_mrd)
  );

  ram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) d3 (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(o3_gnt0), .rvalid0(o3_rv0), .rdata0(o3_rd0), .cpu_stall(o3_stall),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(o3_gnt1), .rvalid1(o3_rv1), .rdata1(o3_rd1),
    .mem_we(o3_we), .mem_addr(o3_addr), .mem_wdata(o3_wdata), .mem_rdata(o3_mrd)
  );

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram1[i] = 32'h0;
      ram3[i] = 32'h0;
    end
    for (int i = 0; i < 3; i++) p3[i] = 32'h0;
    o1_mrd = 32'h0;
  end

  // RAM models: latency 1 and latency 3
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o1_we) ram1[o1_addr[7:0]] <= o1_wdata;
    o1_mrd <= ram1[o1_addr[7:0]];
    if (o3_we) ram3[o3_addr[7:0]] <= o3_wdata;
    p3[0] <= ram3[o3_addr[7:0]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign o3_mrd = p3[2];

  always_comb begin
    m_gnt0  = sel3 ? o3_gnt0  : o1_gnt0;
    m_gnt1  = sel3 ? o3_gnt1  : o1_gnt1;
    m_rv0   = sel3 ? o3_rv0   : o1_rv0;
    m_rv1   = sel3 ? o3_rv1   : o1_rv1;
    m_rd0   = sel3 ? o3_rd0   : o1_rd0;
    m_rd1   = sel3 ? o3_rd1   : o1_rd1;
    m_stall = sel3 ? o3_stall : o1_stall;
    m_we    = sel3 ? o3_we    : o1_we;
    m_addr  = sel3 ? o3_addr  : o1_addr;
    m_wdata = sel3 ? o3_wdata : o1_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] dd1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = dd1;
  endtask

  task automatic push_g(input int c, input bit p, input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.port = p; e.we = w; e.addr = a; e.data = d;
    qg.push_back(e);
  endtask

  task automatic push_r(input int c, input bit p, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.port = p; e.we = 1'b0; e.addr = 32'h0; e.data = d;
    qr.push_back(e);
  endtask

  // Monitor: every grant and every read return must match the next scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (m_gnt0 || m_gnt1) begin
        chk("gnt_single", 32'(m_gnt0 & m_gnt1), 32'h0);
        if (qg.size() == 0) begin
          chk("gnt_unexpected", 32'(m_gnt1), 32'hFFFFFFFF);
        end else begin
          e = qg.pop_front();
          chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
          chk("gnt_port", 32'(m_gnt1), 32'(e.port));
          chk("gnt_mem_we", 32'(m_we), 32'(e.we));
          chk("gnt_mem_addr", m_addr, e.addr);
          if (e.we) chk("gnt_mem_wdata", m_wdata, e.data);
        end
      end
      if (m_rv0 || m_rv1) begin
        chk("rvalid_single", 32'(m_rv0 & m_rv1), 32'h0);
        if (qr.size() == 0) begin
          chk("rvalid_unexpected", 32'(m_rv1), 32'hFFFFFFFF);
        end else begin
          e = qr.pop_front();
          chk("rvalid_cycle", 32'(cyc), 32'(e.cyc));
          chk("rvalid_port", 32'(m_rv1), 32'(e.port));
          chk("rdata", e.port ? m_rd1 : m_rd0, e.data);
          chk("rdata_other_zero", e.port ? m_rd0 : m_rd1, 32'h0);
        end
      end
    end
  end

  int t, u, r, s;

  initial begin
    // Reset: outputs stay quiet even with a request pending
    drv(1, 1, 32'h10, 32'h1, 0, 0, 0, 0);
    tick(); tick();
    @(negedge clk);
    chk("rst_gnt0", 32'(o1_gnt0), 32'h0);
    chk("rst_stall", 32'(o1_stall), 32'h0);
    chk("rst_mem_we", 32'(o1_we), 32'h0);
    chk("rst_mem_addr", o1_addr, 32'h0);
    tick();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // RD_LAT=1: CPU write, then read-back
    drv(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    push_g(cyc, 0, 1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("w0_stall", 32'(m_stall), 32'h0);
    chk("w0_mem_we", 32'(m_we), 32'h1);
    chk("w0_mem_addr", m_addr, 32'h10);
    tick();
    t = cyc;
    drv(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
    push_g(t, 0, 0, 32'h10, 32'h0);
    push_r(t + 1, 0, 32'hDEADBEEF);
    @(negedge clk);
    chk("r0_stall_T", 32'(m_stall), 32'h1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("r0_stall_T1", 32'(m_stall), 32'h0);
    tick();
    drv(0, 0, 0, 0, 1, 1, 32'h20, 32'h11112222);
    push_g(cyc, 1, 1, 32'h20, 32'h11112222);
    tick();

    // Both ports saturating with reads: grants alternate 0,1,0,1
    u = cyc;
    drv(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
    push_g(u,     0, 0, 32'h10, 0);
    push_g(u + 1, 1, 0, 32'h20, 0);
    push_g(u + 2, 0, 0, 32'h10, 0);
    push_g(u + 3, 1, 0, 32'h20, 0);
    push_r(u + 1, 0, 32'hDEADBEEF);
    push_r(u + 2, 1, 32'h11112222);
    push_r(u + 3, 0, 32'hDEADBEEF);
    push_r(u + 4, 1, 32'h11112222);
    tick(); tick(); tick(); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();

    // Switch to the RD_LAT=3 instance through a reset
    rst = 1'b1;
    sel3 = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    drv(0, 0, 0, 0, 1, 1, 32'h20, 32'h11112222);
    push_g(cyc, 1, 1, 32'h20, 32'h11112222);
    tick();
    t = cyc;
    drv(0, 0, 0, 0, 1, 0, 32'h20, 0);
    push_g(t, 1, 0, 32'h20, 0);
    push_r(t + 3, 1, 32'h11112222);
    push_g(t + 3, 0, 1, 32'h30, 32'hCAFEF00D);
    tick();
    drv(1, 1, 32'h30, 32'hCAFEF00D, 0, 0, 0, 0);
    @(negedge clk);
    chk("lat3_stall_T1", 32'(m_stall), 32'h1);
    tick();
    @(negedge clk);
    chk("lat3_stall_T2", 32'(m_stall), 32'h1);
    chk("lat3_hold_addr", m_addr, 32'h20);
    chk("lat3_hold_we", 32'(m_we), 32'h0);
    tick();
    @(negedge clk);
    chk("lat3_stall_T3", 32'(m_stall), 32'h0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Reset during an RD_LAT=3 read: read is discarded
    r = cyc;
    drv(1, 0, 32'h30, 0, 0, 0, 0, 0);
    push_g(r, 0, 0, 32'h30, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_gnt", 32'({o3_gnt0, o3_gnt1}), 32'h0);
    chk("midrst_rvalid", 32'({o3_rv0, o3_rv1}), 32'h0);
    chk("midrst_rdata0", o3_rd0, 32'h0);
    chk("midrst_mem_we", 32'(o3_we), 32'h0);
    chk("midrst_mem_addr", o3_addr, 32'h0);
    chk("midrst_stall", 32'(o3_stall), 32'h0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();

    // First grant after reset goes to port 0 when both request
    s = cyc;
    drv(1, 0, 32'h30, 0, 1, 0, 32'h20, 0);
    push_g(s, 0, 0, 32'h30, 0);
    push_r(s + 3, 0, 32'hCAFEF00D);
    push_g(s + 3, 1, 0, 32'h20, 0);
    push_r(s + 6, 1, 32'h11112222);
    tick();
    req0 = 1'b0;
    tick(); tick(); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();

    @(negedge clk);
    chk("grants_outstanding", 32'(qg.size()), 32'h0);
    chk("reads_outstanding", 32'(qr.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
